// File: rtl/inst_rom_loader_pkg.sv
// Shared types and encodings for the instruction ROM loader.
// Bus widths match the moquanmips fetch port.
package inst_rom_loader_pkg;

  localparam int InstBusW  = 32;
  localparam int InstAddrW = 32;
  localparam int LoadByteW = 8;

  localparam logic RstEnable = 1'b1;

  typedef logic [InstBusW-1:0]  inst_bus_t;
  typedef logic [InstAddrW-1:0] inst_addr_bus_t;
  typedef logic [LoadByteW-1:0] load_byte_bus_t;

  typedef enum logic {
    LoadStLoad = 1'b0,
    LoadStRun  = 1'b1
  } load_st_e;

endpackage

// File: rtl/inst_rom_loader_packer.sv
// Big-endian byte-to-word assembler for the ROM load stream.
// Emits a zero-padded word on the 4th byte or on the last byte.
module inst_word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [LoadByteW-1:0] byte_data,
  input  logic                 byte_last,
  output logic                 word_valid,
  output logic [InstBusW-1:0]  word
);

  logic [1:0]          cnt_q;
  logic [InstBusW-1:0] asm_q;
  logic [InstBusW-1:0] shifted;

  always_comb begin
    shifted = {byte_data, 24'b0} >> {cnt_q, 3'b000};
  end

  assign word       = asm_q | shifted;
  assign word_valid = byte_valid && (cnt_q == 2'd3 || byte_last);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      cnt_q <= 2'd0;
      asm_q <= '0;
    end else if (word_valid) begin
      cnt_q <= 2'd0;
      asm_q <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + 2'd1;
      asm_q <= word;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Loadable instruction ROM for moquanmips; holds the core in reset while loading.
// INST_ROM_CHECKSUM_EN enables the running 32-bit checksum of written words.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [InstAddrW-1:0]  rom_addr_i,
  output logic [InstBusW-1:0]   rom_data_o,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [LoadByteW-1:0]  load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_rst_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic                  overflow_o,
  output logic [31:0]           checksum_o
);

  localparam int Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PtrOne = 1;
  localparam logic [ADDR_WIDTH:0]   CntOne = 1;

  load_st_e state_q, state_d;

  logic [InstBusW-1:0]   mem [Depth];
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  ovf_q;
  logic                  cpu_rst_q;
  logic                  accept;
  logic                  word_valid;
  logic [InstBusW-1:0]   word;
  logic                  wptr_full;
  logic                  unused_addr;

  assign load_ready = (state_q == LoadStLoad) && !load_start;
  assign accept     = load_valid && load_ready;
  assign wptr_full  = (wptr_q == {ADDR_WIDTH{1'b1}});

  inst_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .byte_valid (accept),
    .byte_data  (load_data),
    .byte_last  (load_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = LoadStLoad;
    end else if (word_valid && (load_last || wptr_full)) begin
      state_d = LoadStRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= LoadStLoad;
      cpu_rst_q <= 1'b1;
      wptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d == LoadStLoad);
      if (load_start) begin
        wptr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (word_valid) begin
        wptr_q  <= wptr_q + PtrOne;
        count_q <= count_q + CntOne;
        if (wptr_full && !load_last) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem[wptr_q] <= word;
    end
  end

`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || load_start) begin
      sum_q <= '0;
    end else if (word_valid) begin
      sum_q <= sum_q + word;
    end
  end

  assign checksum_o = sum_q;
`else
  assign checksum_o = '0;
`endif

  always_comb begin
    rom_data_o = '0;
    if (rom_ce_i && state_q == LoadStRun) begin
      rom_data_o = mem[rom_addr_i[ADDR_WIDTH+1:2]];
    end
  end

  assign unused_addr = ^{rom_addr_i[InstAddrW-1:ADDR_WIDTH+2],
                         rom_addr_i[1:0]};

  assign cpu_rst_o    = cpu_rst_q;
  assign word_count_o = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized self-checking bench for inst_rom_loader (ADDR_WIDTH=2).
// Reference model derives words, counts and flags from whole images.
module tb_inst_rom_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int CAP   = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_i;
  logic [31:0]   rom_addr_i;
  logic [31:0]   rom_data_o;
  logic          load_start;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_last;
  logic          load_ready;
  logic          cpu_rst_o;
  logic [AW:0]   word_count_o;
  logic          overflow_o;
  logic [31:0]   checksum_o;

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .cpu_rst_o    (cpu_rst_o),
    .word_count_o (word_count_o),
    .overflow_o   (overflow_o),
    .checksum_o   (checksum_o)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [31:0] mem_m [DEPTH];
  bit          written [DEPTH];
  logic [7:0]  q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    q.push_back(w[31:24]);
    q.push_back(w[23:16]);
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
  endfunction

  task automatic read_word(input int a, input logic [31:0] exp,
                           input string tag);
    @(negedge clk);
    rom_ce_i   = 1'b1;
    rom_addr_i = ($urandom() & 32'hFFFF_FFF0) | (32'(a) << 2)
               | 32'($urandom_range(0, 3));
    #1 chk(tag, rom_data_o, exp);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h55;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    #1 chk("start ready", 32'(load_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("start cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("start rom_data", rom_data_o, 32'd0);
    chk("start count", 32'(word_count_o), 32'd0);
    chk("start ovf", 32'(overflow_o), 32'd0);
    chk("start csum", checksum_o, 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    rom_ce_i   = 1'b0;
    #1 chk("start ready back", 32'(load_ready), 32'd1);
  endtask

  task automatic load_image(input logic [7:0] b[$], input bit last,
                            input bit gaps, input string tag);
    int n;
    int k;
    int nw;
    bit run;
    bit ovf;
    logic [31:0] sum;
    logic [31:0] w;
    n = b.size();
    if (last && n <= CAP) begin
      k = n; run = 1'b1; ovf = 1'b0;
    end else if (n >= CAP) begin
      k = CAP; run = 1'b1; ovf = 1'b1;
    end else begin
      k = n; run = 1'b0; ovf = 1'b0;
    end
    nw  = run ? (k + 3) / 4 : k / 4;
    sum = '0;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * wi + j < k) w |= 32'(b[4 * wi + j]) << (8 * (3 - j));
      end
      mem_m[wi]   = w;
      written[wi] = 1'b1;
      sum += w;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 8'($urandom);
      end
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = b[i];
      load_last  = last && (i == n - 1);
      #1 chk({tag, " ready"}, 32'(load_ready), 32'(i < k));
      @(posedge clk);
      #1 chk({tag, " cpu_rst"}, 32'(cpu_rst_o), 32'(!(run && i >= k - 1)));
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    #1;
    chk({tag, " count"}, 32'(word_count_o), 32'(nw));
    chk({tag, " ovf"}, 32'(overflow_o), 32'(ovf));
`ifdef INST_ROM_CHECKSUM_EN
    chk({tag, " csum"}, checksum_o, sum);
`else
    chk({tag, " csum"}, checksum_o, 32'd0);
`endif
    if (run) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (written[a]) read_word(a, mem_m[a], {tag, " read"});
      end
    end else begin
      read_word(0, 32'd0, {tag, " read gated"});
    end
    rom_ce_i = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rom_ce_i   = 1'b0;
    rom_addr_i = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    for (int a = 0; a < DEPTH; a++) written[a] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rom_ce_i = 1'b1;
    #1;
    chk("rst cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("rst count", 32'(word_count_o), 32'd0);
    chk("rst ovf", 32'(overflow_o), 32'd0);
    chk("rst csum", checksum_o, 32'd0);
    chk("rst ready", 32'(load_ready), 32'd1);
    chk("rst rom_data", rom_data_o, 32'd0);
    rom_ce_i = 1'b0;
    rst      = 1'b0;

    q.delete();
    push_word(32'h3C01_1234);
    push_word(32'h2421_0001);
    load_image(q, 1'b1, 1'b0, "two");
    read_word(1, 32'h2421_0001, "two addr4");
    read_word(0, 32'h3C01_1234, "two addr0");
    chk("two count", 32'(word_count_o), 32'd2);

    start_pulse();
    q.delete();
    push_word(32'hAABB_CCDD);
    q.push_back(8'hEE);
    load_image(q, 1'b1, 1'b0, "pad");
    read_word(1, 32'hEE00_0000, "pad word1");
    chk("pad count", 32'(word_count_o), 32'd2);

    start_pulse();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    load_image(q, 1'b0, 1'b0, "ovf");
    chk("ovf flag", 32'(overflow_o), 32'd1);
    chk("ovf count", 32'(word_count_o), 32'd4);

    start_pulse();
    q.delete();
    q.push_back(8'hDE);
    q.push_back(8'hAD);
    load_image(q, 1'b0, 1'b0, "part");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst count", 32'(word_count_o), 32'd0);
    chk("midrst cpu_rst", 32'(cpu_rst_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    push_word(32'h1122_3344);
    load_image(q, 1'b1, 1'b0, "after rst");
    read_word(0, 32'h1122_3344, "after rst word0");

    start_pulse();
    q.delete();
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    load_image(q, 1'b1, 1'b0, "wrap");
`ifdef INST_ROM_CHECKSUM_EN
    chk("wrap csum", checksum_o, 32'h0000_0001);
`else
    chk("wrap csum", checksum_o, 32'h0000_0000);
`endif

    repeat (12) begin
      int n;
      bit last;
      start_pulse();
      n    = $urandom_range(1, 20);
      last = ($urandom_range(0, 3) != 0);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load_image(q, last, 1'b1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
